// File: rtl/button_events_pkg.sv
// Shared types and helpers for the button event decoder.
package button_events_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_PRESSED,
    BTN_HELD
  } t_btn_state;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_timer.sv
// Tick counter with terminal compare. Hit is combinational and the count self-clears on it,
// so the count never wraps.
module button_timer #(
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [CNT_BITS-1:0] cmp,
  output logic                hit
);

  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_BITS'(1);
  assign hit     = en & ~clr & (cnt_inc == cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || hit) cnt <= '0;
    else if (en)         cnt <= cnt_inc;
  end

endmodule

// File: rtl/button_events.sv
// Debounced button level -> registered press/release/click/long/repeat pulses.
// Hold time is measured in in_tick strobes.
module button_events
  import button_events_pkg::*;
#(
  parameter int LONG_TICKS    = 1000,
  parameter int REPEAT_TICKS  = 200,
  parameter int REPEAT_ENABLE = 1,
  parameter int CNT_BITS      = $clog2(max_int(LONG_TICKS, REPEAT_TICKS)) + 1
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_tick,
  input  logic in_button,
  output logic out_pressed,
  output logic out_press,
  output logic out_release,
  output logic out_click,
  output logic out_long,
  output logic out_repeat
);

  generate
    if (LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
      $error("button_events: LONG_TICKS and REPEAT_TICKS must be >= 1");
    end
  endgenerate

  localparam logic [CNT_BITS-1:0] LONG_CMP   = CNT_BITS'(LONG_TICKS);
  localparam logic [CNT_BITS-1:0] REPEAT_CMP = CNT_BITS'(REPEAT_TICKS);
  localparam logic                REP_EN     = (REPEAT_ENABLE != 0);

  t_btn_state          state_q, state_d;
  logic                pressed_d, press_d, release_d, click_d, long_d, repeat_d;
  logic                tmr_clr, tmr_en, tmr_hit;
  logic [CNT_BITS-1:0] tmr_cmp;

  button_timer #(.CNT_BITS(CNT_BITS)) u_timer (
    .clk   (in_clk),
    .rst_n (in_rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .cmp   (tmr_cmp),
    .hit   (tmr_hit)
  );

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    tmr_cmp   = LONG_CMP;
    case (state_q)
      BTN_IDLE: begin
        tmr_clr = 1'b1;
        if (in_button) begin
          state_d = BTN_PRESSED;
          press_d = 1'b1;
        end
      end
      BTN_PRESSED: begin
        if (!in_button) begin
          state_d   = BTN_IDLE;
          release_d = 1'b1;
          click_d   = 1'b1;
          tmr_clr   = 1'b1;
        end else begin
          // out_press is high exactly in the entry cycle, which never counts a tick
          tmr_en = in_tick & ~out_press;
          if (tmr_hit) begin
            state_d = BTN_HELD;
            long_d  = 1'b1;
          end
        end
      end
      BTN_HELD: begin
        tmr_cmp = REPEAT_CMP;
        if (!in_button) begin
          state_d   = BTN_IDLE;
          release_d = 1'b1;
          tmr_clr   = 1'b1;
        end else begin
          tmr_en = in_tick & REP_EN;
          if (tmr_hit) repeat_d = 1'b1;
        end
      end
      default: begin
        state_d = BTN_IDLE;
        tmr_clr = 1'b1;
      end
    endcase
    pressed_d = (state_d != BTN_IDLE);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= BTN_IDLE;
      out_pressed <= 1'b0;
      out_press   <= 1'b0;
      out_release <= 1'b0;
      out_click   <= 1'b0;
      out_long    <= 1'b0;
      out_repeat  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_pressed <= pressed_d;
      out_press   <= press_d;
      out_release <= release_d;
      out_click   <= click_d;
      out_long    <= long_d;
      out_repeat  <= repeat_d;
    end
  end

endmodule

// File: tb/tb_button_events.sv
// Directed vector table for button_events (LONG=4, REPEAT=2), plus hand sequences
// for tick gating, REPEAT_ENABLE=0 and asynchronous reset mid-hold.
module tb_button_events;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: repeat enabled
  logic rst_a = 1'b0, tick_a = 1'b0, btn_a = 1'b0;
  logic pressed_a, press_a, release_a, click_a, long_a, repeat_a;
  // DUT B: repeat disabled
  logic rst_b = 1'b0, tick_b = 1'b0, btn_b = 1'b0;
  logic pressed_b, press_b, release_b, click_b, long_b, repeat_b;

  button_events #(.LONG_TICKS(4), .REPEAT_TICKS(2), .REPEAT_ENABLE(1)) dut_a (
    .in_clk(clk), .in_rst(rst_a), .in_tick(tick_a), .in_button(btn_a),
    .out_pressed(pressed_a), .out_press(press_a), .out_release(release_a),
    .out_click(click_a), .out_long(long_a), .out_repeat(repeat_a)
  );

  button_events #(.LONG_TICKS(4), .REPEAT_TICKS(2), .REPEAT_ENABLE(0)) dut_b (
    .in_clk(clk), .in_rst(rst_b), .in_tick(tick_b), .in_button(btn_b),
    .out_pressed(pressed_b), .out_press(press_b), .out_release(release_b),
    .out_click(click_b), .out_long(long_b), .out_repeat(repeat_b)
  );

  // {pressed, press, release, click, long, repeat}
  logic [5:0] outs_a, outs_b;
  assign outs_a = {pressed_a, press_a, release_a, click_a, long_a, repeat_a};
  assign outs_b = {pressed_b, press_b, release_b, click_b, long_b, repeat_b};

  localparam logic [5:0] O_ZERO = 6'b000000;
  localparam logic [5:0] O_HOLD = 6'b100000;
  localparam logic [5:0] O_PRS  = 6'b110000;
  localparam logic [5:0] O_CLK  = 6'b001100;
  localparam logic [5:0] O_REL  = 6'b001000;
  localparam logic [5:0] O_LONG = 6'b100010;
  localparam logic [5:0] O_REP  = 6'b100001;

  typedef struct {
    logic       rst;
    logic       tick;
    logic       btn;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input logic r, input logic t, input logic b, input logic [5:0] e);
    vec_t v;
    v.rst = r; v.tick = t; v.btn = b; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int nlong, nrep, long_idx;

    // reset held with button high, then 1-cycle minimum press
    repeat (3) add(1'b0, 1'b0, 1'b1, O_ZERO);
    add(1'b1, 1'b0, 1'b1, O_PRS);
    add(1'b1, 1'b0, 1'b0, O_CLK);
    add(1'b1, 1'b0, 1'b0, O_ZERO);
    // short click, tick every cycle, button high 3 cycles
    add(1'b1, 1'b1, 1'b1, O_PRS);
    add(1'b1, 1'b1, 1'b1, O_HOLD);
    add(1'b1, 1'b1, 1'b1, O_HOLD);
    add(1'b1, 1'b1, 1'b0, O_CLK);
    add(1'b1, 1'b1, 1'b0, O_ZERO);
    // long + repeat, button held 12 cycles; entry cycle ignores its tick
    add(1'b1, 1'b1, 1'b1, O_PRS);
    repeat (4) add(1'b1, 1'b1, 1'b1, O_HOLD);
    add(1'b1, 1'b1, 1'b1, O_LONG);
    repeat (3) begin
      add(1'b1, 1'b1, 1'b1, O_HOLD);
      add(1'b1, 1'b1, 1'b1, O_REP);
    end
    add(1'b1, 1'b1, 1'b0, O_REL);
    add(1'b1, 1'b1, 1'b0, O_ZERO);
    // release coincides with the 4th tick: click wins, no long
    add(1'b1, 1'b1, 1'b1, O_PRS);
    repeat (4) add(1'b1, 1'b1, 1'b1, O_HOLD);
    add(1'b1, 1'b1, 1'b0, O_CLK);
    add(1'b1, 1'b1, 1'b0, O_ZERO);
    // release in HELD coinciding with a repeat tick
    add(1'b1, 1'b1, 1'b1, O_PRS);
    repeat (4) add(1'b1, 1'b1, 1'b1, O_HOLD);
    add(1'b1, 1'b1, 1'b1, O_LONG);
    add(1'b1, 1'b1, 1'b1, O_HOLD);
    add(1'b1, 1'b1, 1'b0, O_REL);

    check("reset_state", 0, {26'd0, outs_a}, {26'd0, O_ZERO});
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst; tick_a = vecs[i].tick; btn_a = vecs[i].btn;
      @(posedge clk); #1;
      check("vec", i, {26'd0, outs_a}, {26'd0, vecs[i].exp});
    end

    // tick gating: tick every 3rd cycle, 4th counted tick lands at i=11
    btn_a = 1'b0; tick_a = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      btn_a = 1'b1;
      tick_a = (i % 3 == 2);
      @(posedge clk); #1;
      check("gate_long", i, {31'd0, long_a}, {31'd0, (i == 11)});
      check("gate_pressed", i, {31'd0, pressed_a}, 32'd1);
    end

    // REPEAT_ENABLE=0: held 20 cycles with tick every cycle
    rst_b = 1'b1; btn_b = 1'b1; tick_b = 1'b1;
    nlong = 0; nrep = 0; long_idx = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (long_b) begin nlong++; long_idx = i; end
      if (repeat_b) nrep++;
    end
    check("norep_long_count", 0, nlong, 1);
    check("norep_long_pos", 0, long_idx, 5);
    check("norep_repeat_count", 0, nrep, 0);
    check("norep_pressed", 0, {31'd0, pressed_b}, 32'd1);

    // asynchronous reset mid-hold clears outputs before any clock edge
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("async_rst", 0, {26'd0, outs_b}, {26'd0, O_ZERO});
    @(posedge clk); #1;
    check("async_rst", 1, {26'd0, outs_b}, {26'd0, O_ZERO});
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("rst_press", 0, {26'd0, outs_b}, {26'd0, O_PRS});
    btn_b = 1'b0;
    @(posedge clk); #1;
    check("rst_click", 0, {26'd0, outs_b}, {26'd0, O_CLK});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
